// File: rtl/ifu_lat_rom.sv
// AXI4-Lite read-only instruction memory for the fetch path.
// Each fetch is delayed by a fixed or LFSR-random number of wait cycles.
module ifu_lat_rom #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        DEPTH     = 4096,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h8000_0000,
    parameter string              INIT_FILE = "",
    parameter bit                 RAND_EN   = 1'b0,
    parameter int unsigned        FIX_DELAY = 10,
    parameter int unsigned        MIN_DELAY = 1,
    parameter logic [7:0]         RAND_MASK = 8'h0F,
    parameter logic [15:0]        LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    localparam int unsigned   IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN   = (ADDR_W+1)'(64'(DEPTH) * 64'd4);
    localparam logic [1:0]    RESP_OK  = 2'b00;
    localparam logic [1:0]    RESP_ERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q,   state_d;
    logic [7:0]        cnt_q,     cnt_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [15:0]       lfsr_q,    lfsr_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    logic [31:0]       rand_sum_c;
    logic [7:0]        dly_c;
    logic [ADDR_W-1:0] off_c;
    logic              addr_err_c;
    logic [IDX_W-1:0]  rd_idx_c;

    // Wait-cycle count for a new fetch, saturated to 8 bits.
    always_comb begin
        rand_sum_c = 32'(MIN_DELAY) + 32'(lfsr_q[7:0] & RAND_MASK);
        if (RAND_EN) begin
            dly_c = (rand_sum_c > 32'd255) ? 8'hFF : rand_sum_c[7:0];
        end else begin
            dly_c = (FIX_DELAY > 32'd255) ? 8'hFF : 8'(FIX_DELAY);
        end
    end

    // Below-base addresses wrap to huge offsets and fail the range test.
    always_comb begin
        off_c      = addr_q - BASE_ADDR;
        addr_err_c = (addr_q[1:0] != 2'b00) || ({1'b0, off_c} >= SPAN);
        rd_idx_c   = off_c[IDX_W+1:2];
    end

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    addr_d    = araddr;
                    cnt_d     = dly_c;
                    arready_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = addr_err_c ? '0 : mem[rd_idx_c];
                    rresp_d  = addr_err_c ? RESP_ERR : RESP_OK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                rvalid_d = 1'b1;
                if (rvalid_q && rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            lfsr_q    <= lfsr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_ifu_lat_rom.sv
// Scoreboard bench for ifu_lat_rom: three instances (D=10, D=0, LFSR-random),
// expected responses queued at issue time and checked by per-instance monitors.
`timescale 1ns/1ps
module tb_ifu_lat_rom;

    localparam int unsigned NDUT  = 3;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 4096;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int unsigned NSEQ  = 16384;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [8:0]  lat;
        logic [31:0] hs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr  [NDUT];
    logic        arvalid [NDUT];
    logic        arready [NDUT];
    logic [31:0] rdata   [NDUT];
    logic [1:0]  rresp   [NDUT];
    logic        rvalid  [NDUT];
    logic        rready  [NDUT];
    int          rr_mode [NDUT];

    exp_t        sb [NDUT][$];
    int unsigned n_resp [NDUT];
    int unsigned lat_log [$];
    logic [31:0] img [DEPTH];
    logic [15:0] lfsr_seq [NSEQ];
    int unsigned cyc = 0;
    int unsigned steps = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) steps <= rst ? 0 : steps + 1;

    ifu_lat_rom #(.RAND_EN(1'b0), .FIX_DELAY(10)) u_fix (
        .clk(clk), .rst(rst), .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]));

    ifu_lat_rom #(.RAND_EN(1'b0), .FIX_DELAY(0)) u_zero (
        .clk(clk), .rst(rst), .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]));

    ifu_lat_rom #(.RAND_EN(1'b1), .MIN_DELAY(1), .RAND_MASK(8'h0F), .LFSR_SEED(SEED)) u_rnd (
        .clk(clk), .rst(rst), .araddr(araddr[2]), .arvalid(arvalid[2]), .arready(arready[2]),
        .rdata(rdata[2]), .rresp(rresp[2]), .rvalid(rvalid[2]), .rready(rready[2]));

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Reference read: byte offset from base, word-aligned and inside the array or SLVERR.
    function automatic exp_t model_rd(input logic [31:0] a, input int unsigned d, input int unsigned hs);
        exp_t        e;
        logic [31:0] off;
        off    = a - BASE;
        e.lat  = 9'(d + 1);
        e.hs   = hs;
        if (a[1:0] != 2'b00 || off >= DEPTH * 4) begin
            e.data = 32'h0;
            e.resp = 2'b10;
        end else begin
            e.data = img[off[13:2]];
            e.resp = 2'b00;
        end
        return e;
    endfunction

    function automatic int unsigned delay_of(input int k);
        logic [15:0] l;
        int unsigned v;
        if (k == 0) return 10;
        if (k == 1) return 0;
        l = lfsr_seq[steps % NSEQ];
        v = 1 + 32'(l[7:0] & 8'h0F);
        return (v > 255) ? 255 : v;
    endfunction

    // Called on a negedge; returns on the negedge right after the AR handshake.
    task automatic issue(input int k, input logic [31:0] a);
        int budget;
        budget     = 0;
        araddr[k]  = a;
        arvalid[k] = 1'b1;
        while (arready[k] !== 1'b1) begin
            @(negedge clk);
            budget++;
            if (budget > 400) begin
                chk("ar_timeout", k, 64'(arready[k]), 64'd1);
                arvalid[k] = 1'b0;
                return;
            end
        end
        sb[k].push_back(model_rd(a, delay_of(k), cyc + 1));
        @(negedge clk);
        arvalid[k] = 1'b0;
        araddr[k]  = $urandom;
    endtask

    task automatic wait_drain(input int k);
        int budget;
        budget = 0;
        while (sb[k].size() != 0 || rvalid[k] === 1'b1) begin
            @(negedge clk);
            budget++;
            if (budget > 600) begin
                chk("drain_timeout", k, 64'(sb[k].size()), 64'd0);
                sb[k].delete();
                return;
            end
        end
    endtask

    // rready driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                if (rr_mode[k] == 0) rready[k] = 1'b1;
                else if (rr_mode[k] == 1) rready[k] = ($urandom_range(0, 3) != 0);
            end
        end
    end

    for (genvar k = 0; k < NDUT; k++) begin : g_mon
        exp_t        cur;
        bit          active;
        int unsigned lat;
        initial begin
            active = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    active = 1'b0;
                end else if (rvalid[k] === 1'b1) begin
                    if (!active) begin
                        if (sb[k].size() == 0) begin
                            chk("unexpected_rvalid", k, 64'(rvalid[k]), 64'd0);
                        end else begin
                            cur    = sb[k].pop_front();
                            active = 1'b1;
                            lat    = cyc - cur.hs;
                            chk("latency", k, 64'(lat), 64'(cur.lat));
                            n_resp[k]++;
                            if (k == 2) lat_log.push_back(lat);
                        end
                    end
                    if (active) begin
                        chk("rdata", k, 64'(rdata[k]), 64'(cur.data));
                        chk("rresp", k, 64'(rresp[k]), 64'(cur.resp));
                        chk("arready_busy", k, 64'(arready[k]), 64'd0);
                        if (rready[k] === 1'b1) active = 1'b0;
                    end
                end else if (active) begin
                    chk("rvalid_dropped", k, 64'(rvalid[k]), 64'd1);
                    active = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: cycle %0d reached, required completion earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] err_addr [4];
        logic [15:0] t;
        bit          seen [256];
        int          distinct;
        int          budget;

        for (int k = 0; k < NDUT; k++) begin
            araddr[k] = 32'h0; arvalid[k] = 1'b0; rready[k] = 1'b1; rr_mode[k] = 0; n_resp[k] = 0;
        end
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        img[0] = 32'h0000_0413;
        img[1] = 32'h0010_0093;
        for (int i = 0; i < DEPTH; i++) begin
            u_fix.mem[i]  = img[i];
            u_zero.mem[i] = img[i];
            u_rnd.mem[i]  = img[i];
        end
        lfsr_seq[0] = SEED;
        for (int i = 1; i < NSEQ; i++) begin
            t = lfsr_seq[i-1];
            lfsr_seq[i] = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_arready", k, 64'(arready[k]), 64'd0);
            chk("rst_rvalid", k, 64'(rvalid[k]), 64'd0);
            chk("rst_rdata", k, 64'(rdata[k]), 64'd0);
            chk("rst_rresp", k, 64'(rresp[k]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) chk("arready_after_rst", k, 64'(arready[k]), 64'd1);

        // Fixed latency 10, rready always high.
        issue(0, BASE);
        budget = 0;
        while (rvalid[0] !== 1'b1 && budget < 40) begin @(negedge clk); budget++; end
        @(negedge clk);
        chk("arready_reopen", 0, 64'(arready[0]), 64'd1);
        chk("rvalid_closed", 0, 64'(rvalid[0]), 64'd0);
        wait_drain(0);

        // Error and boundary addresses.
        err_addr[0] = 32'h8000_0002;
        err_addr[1] = 32'h8000_4000;
        err_addr[2] = 32'h7FFF_FFFC;
        err_addr[3] = 32'h8000_3FFC;
        for (int i = 0; i < 4; i++) begin
            issue(0, err_addr[i]);
            wait_drain(0);
        end

        // Zero latency with seven cycles of backpressure.
        rr_mode[1] = 2;
        rready[1]  = 1'b0;
        issue(1, BASE + 32'h4);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            chk("bp_rvalid", 1, 64'(rvalid[1]), 64'd1);
            chk("bp_arready", 1, 64'(arready[1]), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rready[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_done_rvalid", 1, 64'(rvalid[1]), 64'd0);
        chk("bp_done_arready", 1, 64'(arready[1]), 64'd1);
        rr_mode[1] = 0;
        wait_drain(1);

        // Reset three cycles into a read aborts it.
        issue(0, BASE + 32'h8);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) sb[k].delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst_arready", 0, 64'(arready[0]), 64'd0);
            chk("midrst_rvalid", 0, 64'(rvalid[0]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_arready", 0, 64'(arready[0]), 64'd1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("aborted_rvalid", 0, 64'(rvalid[0]), 64'd0);
        end
        issue(0, BASE + 32'hC);
        wait_drain(0);

        // A second request during WAIT must be ignored.
        issue(0, BASE + 32'h10);
        araddr[0]  = BASE + 32'h14;
        arvalid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_arready", 0, 64'(arready[0]), 64'd0);
        end
        arvalid[0] = 1'b0;
        wait_drain(0);
        repeat (5) @(negedge clk);

        // Random-latency back-to-back reads with random backpressure.
        rr_mode[2] = 1;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
                1: a = BASE + 32'h4000 + (32'($urandom_range(0, 255)) << 2);
                2: a = BASE - 32'h4 - (32'($urandom_range(0, 255)) << 2);
                default: a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
            endcase
            issue(2, a);
        end
        wait_drain(2);
        repeat (3) @(negedge clk);

        chk("rnd_resp_count", 2, 64'(n_resp[2]), 64'd200);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        foreach (lat_log[i]) begin
            chk("lat_range", 2, 64'(lat_log[i] >= 2 && lat_log[i] <= 17), 64'd1);
            seen[lat_log[i] % 256] = 1'b1;
        end
        distinct = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
        chk("distinct_latencies", 2, 64'(distinct >= 8), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
